// File: rtl/ula_serial_16_pkg.sv
// rtl/ula_serial_16_pkg.sv - shared types and constants for the nibble-serial ALU engine
// State encoding plus the 74181 function selects and carry levels used around the slice.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The slice carry pins are active-low: 1 means no carry.
  localparam logic ULA_CIN_NONE = 1'b1;

  localparam logic [3:0] ULA_S_ADD    = 4'b1001;
  localparam logic [3:0] ULA_S_XOR    = 4'b0110;
  localparam logic [3:0] ULA_S_PASS_A = 4'b1111;
  localparam logic [3:0] ULA_S_NOT_A  = 4'b0000;

endpackage

// File: rtl/ula_serial_16_if.sv
// rtl/ula_serial_16_if.sv - start/busy/done request and result bundle of the serial ALU
// The master issues operands and start; the slave (engine) returns status and results.
interface ula_serial_16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             a_eq_b;
  logic             p;
  logic             g;

  modport master (
    output start, a, b, s, m, c_in,
    input  busy, done, f, c_out, a_eq_b, p, g
  );

  modport slave (
    input  start, a, b, s, m, c_in,
    output busy, done, f, c_out, a_eq_b, p, g
  );
endinterface

// File: rtl/ula_74181.sv
// rtl/ula_74181.sv - 4-bit 74181-style ALU slice, active-high data
// Carry pins are active-low; p and g are the active-high group propagate/generate.
module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       a_eq_b,
  output logic       p,
  output logic       g
);
  logic [3:0] u;
  logic [3:0] v;
  logic [3:0] pi;
  logic [3:0] gi;
  logic [3:0] h;
  logic [4:0] c;

  always_comb begin
    u  = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
    v  = ~((a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}}));
    pi = ~u;
    gi = ~v;
    h  = u ^ v;
    c  = '0;
    c[0] = ~c_in;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = gi[i] | (pi[i] & c[i]);
    end
    // Logic mode suppresses the carry and inverts the half-sum.
    f      = m ? ~h : (h ^ c[3:0]);
    c_out  = ~c[4];
    a_eq_b = &f;
    p      = &pi;
    g      = gi[3] | (pi[3] & (gi[2] | (pi[2] & (gi[1] | (pi[1] & gi[0])))));
  end
endmodule

// File: rtl/ula_serial_16.sv
// rtl/ula_serial_16.sv - multi-word ALU driving one 74181 slice a nibble per cycle
// Carry is chained through a register; equality, propagate and generate accumulate per nibble.
module ula_serial_16
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  ula_serial_16_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [NW-1:0]    nib_q, nib_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             cy_q, cy_d;
  logic             eq_acc_q, eq_acc_d;
  logic             p_acc_q, p_acc_d;
  logic             g_acc_q, g_acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             c_out_q, c_out_d;
  logic             a_eq_b_q, a_eq_b_d;
  logic             p_q, p_d;
  logic             g_q, g_d;

  logic [NW+1:0]    base;
  logic [3:0]       sl_a, sl_b, sl_f;
  logic             sl_cout, sl_eq, sl_p, sl_g;
  logic             last_nib;
  logic             eq_next, p_next, g_next;

  assign base     = {nib_q, 2'b00};
  assign sl_a     = a_q[base +: 4];
  assign sl_b     = b_q[base +: 4];
  assign last_nib = (nib_q == NW'(N - 1));
  assign eq_next  = eq_acc_q & sl_eq;
  assign p_next   = p_acc_q & sl_p;
  assign g_next   = sl_g | (sl_p & g_acc_q);

  ula_74181 u_slice (
    .a      (sl_a),
    .b      (sl_b),
    .s      (s_q),
    .m      (m_q),
    .c_in   (cy_q),
    .f      (sl_f),
    .c_out  (sl_cout),
    .a_eq_b (sl_eq),
    .p      (sl_p),
    .g      (sl_g)
  );

  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    a_d      = a_q;
    b_d      = b_q;
    f_d      = f_q;
    s_d      = s_q;
    m_d      = m_q;
    cy_d     = cy_q;
    eq_acc_d = eq_acc_q;
    p_acc_d  = p_acc_q;
    g_acc_d  = g_acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    c_out_d  = c_out_q;
    a_eq_b_d = a_eq_b_q;
    p_d      = p_q;
    g_d      = g_q;

    unique case (state_q)
      RUN: begin
        f_d[base +: 4] = sl_f;
        cy_d     = sl_cout;
        eq_acc_d = eq_next;
        p_acc_d  = p_next;
        g_acc_d  = g_next;
        if (last_nib) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          c_out_d  = sl_cout;
          a_eq_b_d = eq_next;
          p_d      = p_next;
          g_d      = g_next;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE when start is low.
        if (bus.start) begin
          state_d  = RUN;
          a_d      = bus.a;
          b_d      = bus.b;
          s_d      = bus.s;
          m_d      = bus.m;
          cy_d     = bus.c_in;
          nib_d    = '0;
          eq_acc_d = 1'b1;
          p_acc_d  = 1'b1;
          g_acc_d  = 1'b0;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      nib_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      cy_q     <= 1'b0;
      eq_acc_q <= 1'b0;
      p_acc_q  <= 1'b0;
      g_acc_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_out_q  <= 1'b0;
      a_eq_b_q <= 1'b0;
      p_q      <= 1'b0;
      g_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      nib_q    <= nib_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      s_q      <= s_d;
      m_q      <= m_d;
      cy_q     <= cy_d;
      eq_acc_q <= eq_acc_d;
      p_acc_q  <= p_acc_d;
      g_acc_q  <= g_acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      c_out_q  <= c_out_d;
      a_eq_b_q <= a_eq_b_d;
      p_q      <= p_d;
      g_q      <= g_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.f      = f_q;
  assign bus.c_out  = c_out_q;
  assign bus.a_eq_b = a_eq_b_q;
  assign bus.p      = p_q;
  assign bus.g      = g_q;
endmodule
